io_op_sequencer: RTL

//  Sequences the custom I/O instructions (PPU send, accelerator send, ethernet send, random read,

---
 rtl/io_seq_pkg.sv | 24 ++
 rtl/io_timeout_ctr.sv | 36 +++
 rtl/io_op_sequencer.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/io_seq_pkg.sv
// Shared types for the I/O op sequencer: peripheral target encoding, FSM states and
// a helper that tells whether a target returns read data for writeback.
package io_seq_pkg;

  typedef enum logic [2:0] {
    TgtPpu = 3'd0,
    TgtAcc = 3'd1,
    TgtEth = 3'd2,
    TgtRnd = 3'd3,
    TgtIrq = 3'd4
  } io_tgt_e;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StReq   = 2'd1,
    StDone  = 2'd2,
    StAbort = 2'd3
  } io_state_e;

  function automatic logic tgt_has_rdata(io_tgt_e tgt);
    return (tgt == TgtAcc) || (tgt == TgtRnd) || (tgt == TgtIrq);
  endfunction

endpackage

// File: rtl/io_timeout_ctr.sv
// Request-wait counter: cleared when a request is issued, counts while the request is
// outstanding and flags expiry in the Limit-th waiting cycle.
module io_timeout_ctr #(
  parameter int unsigned Limit = 255,
  parameter int unsigned CntW  = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count value equals the number of request cycles already elapsed.
  assign expired_o = enable_i && (cnt_q == CntW'(Limit - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/io_op_sequencer.sv
// Issues decoded custom I/O ops as single req/ack transactions, stalls the pipeline while
// one is outstanding and returns read data. Define IO_TIMEOUT_EN to abort unacknowledged ops.
module io_op_sequencer
  import io_seq_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              op_valid,
  input  logic              op_ppu,
  input  logic              op_sac,
  input  logic              op_snd,
  input  logic              op_rnd,
  input  logic              op_rdi,
  input  logic [DATA_W-1:0] op_data,
  input  logic              flush,
  output logic              stall,
  output logic              wb_valid,
  output logic [DATA_W-1:0] wb_data,
  output logic              io_req,
  output logic [2:0]        io_tgt,
  output logic [DATA_W-1:0] io_wdata,
  input  logic              io_ack,
  input  logic [DATA_W-1:0] io_rdata,
  output logic              io_err
);

  io_state_e         state_q, state_d;
  io_tgt_e           tgt_q, tgt_d, sel_tgt;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              flushed_q, flushed_d;
  logic              err_q, err_d;
  logic [4:0]        flags;
  logic              multi_flag;
  logic              start;
  logic              in_req;
  logic              abort_err;
  logic              timeout_hit;

  assign flags      = {op_rdi, op_rnd, op_snd, op_sac, op_ppu};
  assign multi_flag = (flags & (flags - 5'd1)) != 5'd0;
  assign start      = (state_q == StIdle) && op_valid && (flags != 5'd0) && !flush;
  assign in_req     = (state_q == StReq);

  always_comb begin
    if (op_ppu) begin
      sel_tgt = TgtPpu;
    end else if (op_sac) begin
      sel_tgt = TgtAcc;
    end else if (op_snd) begin
      sel_tgt = TgtEth;
    end else if (op_rnd) begin
      sel_tgt = TgtRnd;
    end else begin
      sel_tgt = TgtIrq;
    end
  end

`ifdef IO_TIMEOUT_EN
  localparam int unsigned CntW =
      ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;

  logic to_expired;

  io_timeout_ctr #(
    .Limit(TIMEOUT_CYC),
    .CntW (CntW)
  ) u_timeout_ctr (
    .clk_i    (clk),
    .rst_i    (rst),
    .clear_i  (start),
    .enable_i (in_req),
    .expired_o(to_expired)
  );

  assign timeout_hit = to_expired;
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    tgt_d     = tgt_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    flushed_d = flushed_q;
    err_d     = 1'b0;
    stall     = 1'b0;
    io_req    = 1'b0;
    wb_valid  = 1'b0;
    abort_err = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Stall must assert in the decode cycle itself so the op stays in EX.
        if (start) begin
          stall     = 1'b1;
          state_d   = StReq;
          tgt_d     = sel_tgt;
          wdata_d   = op_data;
          flushed_d = 1'b0;
          err_d     = multi_flag;
        end
      end
      StReq: begin
        io_req = 1'b1;
        stall  = 1'b1;
        if (flush) begin
          flushed_d = 1'b1;
        end
        if (io_ack) begin
          rdata_d = io_rdata;
          state_d = StDone;
        end else if (timeout_hit) begin
          rdata_d = '0;
          state_d = StAbort;
        end
      end
      StDone: begin
        wb_valid = tgt_has_rdata(tgt_q) && !flushed_q && !flush;
        state_d  = StIdle;
      end
      StAbort: begin
        abort_err = 1'b1;
        wb_valid  = tgt_has_rdata(tgt_q) && !flushed_q && !flush;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign io_tgt   = tgt_q;
  assign io_wdata = wdata_q;
  assign wb_data  = rdata_q;
  assign io_err   = err_q || abort_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      tgt_q     <= TgtPpu;
      wdata_q   <= '0;
      rdata_q   <= '0;
      flushed_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      tgt_q     <= tgt_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      flushed_q <= flushed_d;
      err_q     <= err_d;
    end
  end

endmodule
